// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone B3 burst constants and next-address helper
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC    = 3'b000;
  localparam logic [2:0] CTI_INCBURST   = 3'b010;
  localparam logic [2:0] CTI_ENDOFBURST = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Wrapping bursts only advance the low address bits; linear carries through
  // the whole word address and the caller truncates to its decoded width.
  function automatic logic [29:0] wb_next_adr(input logic [29:0] a, input logic [1:0] bte);
    logic [29:0] n;
    n = a;
    case (bte)
      BTE_WRAP4:  n[1:0] = a[1:0] + 2'd1;
      BTE_WRAP8:  n[2:0] = a[2:0] + 3'd1;
      BTE_WRAP16: n[3:0] = a[3:0] + 4'd1;
      default:    n = a + 30'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_burst_ram_slave_if.sv
// rtl/wb_burst_ram_slave_if.sv - Wishbone B3 burst bus bundle with master/slave views
interface wb_burst_ram_slave_if;
  logic [31:0] wbs_dat_i;
  logic [29:0] wbs_adr_i;
  logic [3:0]  wbs_sel_i;
  logic [1:0]  wbs_bte_i;
  logic [2:0]  wbs_cti_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bte_i, wbs_cti_i,
           wbs_we_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bte_i, wbs_cti_i,
           wbs_we_i, wbs_cyc_i, wbs_stb_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/vl_ram_be.sv
// rtl/vl_ram_be.sv - single-port synchronous 32-bit RAM with byte enables, registered read
module vl_ram_be #(
  parameter int adr_width = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 we,
  input  logic [3:0]           sel,
  input  logic [adr_width-1:0] adr,
  input  logic [31:0]          wdat,
  output logic [31:0]          rdat
);

  logic [31:0] mem [2**adr_width];
  logic [31:0] merged;

  // Old word with the enabled lanes replaced; doubles as write-first read data.
  always_comb begin
    merged = mem[adr];
    for (int b = 0; b < 4; b++) begin
      if (we && sel[b]) merged[8*b +: 8] = wdat[8*b +: 8];
    end
  end

  // Array write; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[adr] <= merged;
  end

  // Output register, only updated on an access so it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdat <= 32'd0;
    else if (en) rdat <= merged;
  end

endmodule

// File: rtl/wb_burst_ram_slave.sv
// rtl/wb_burst_ram_slave.sv - Wishbone B3 burst-capable RAM responder
module wb_burst_ram_slave
  import wb_pkg::*;
#(
  parameter int adr_width   = 10,
  parameter int wait_cycles = 0
) (
  input  logic          wbs_clk,
  input  logic          wbs_rst,
  wb_burst_ram_slave_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  localparam logic [3:0] wait_load = 4'(wait_cycles);

  state_t                 state, state_d;
  logic                   ack_q, ack_d;
  logic [3:0]             cnt, cnt_d;
  logic [adr_width-1:0]   adr_q, adr_d;
  logic                   ram_en, ram_we;
  logic [adr_width-1:0]   ram_adr;
  logic [adr_width-1:0]   adr_in;
  logic [29:0]            nxt_full;
  logic [adr_width-1:0]   nxt;
  logic                   mismatch;
  logic                   ack;
  logic                   unused_bits;

  assign adr_in      = bus.wbs_adr_i[adr_width-1:0];
  assign nxt_full    = wb_next_adr(30'(adr_q), bus.wbs_bte_i);
  assign nxt         = nxt_full[adr_width-1:0];
  assign unused_bits = &{1'b0, nxt_full[29:adr_width], bus.wbs_adr_i[29:adr_width]};

  // A strobed beat whose address disagrees with the tracked beat address is not acked.
  assign mismatch = (state == BURST) && bus.wbs_stb_i && (adr_in != adr_q);
  assign ack      = ack_q && bus.wbs_cyc_i && bus.wbs_stb_i && !mismatch;

  assign bus.wbs_ack_o = ack;

  // State, ack, wait counter and beat address registers.
  always_ff @(posedge wbs_clk or posedge wbs_rst) begin
    if (wbs_rst) begin
      state <= IDLE;
      ack_q <= 1'b0;
      cnt   <= 4'd0;
      adr_q <= '0;
    end else begin
      state <= state_d;
      ack_q <= ack_d;
      cnt   <= cnt_d;
      adr_q <= adr_d;
    end
  end

  // Next state, RAM port steering and beat address generation.
  always_comb begin
    state_d = state;
    ack_d   = ack_q;
    cnt_d   = cnt;
    adr_d   = adr_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_adr = adr_q;

    case (state)
      IDLE: begin
        ack_d = 1'b0;
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          ram_en  = 1'b1;
          ram_adr = adr_in;
          adr_d   = adr_in;
          if (wait_cycles == 0) begin
            state_d = BURST;
            ack_d   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_load;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_d = BURST;
          ack_d   = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      BURST: begin
        if (mismatch) begin
          // Restart as a fresh access at the address the master presents.
          ram_en  = 1'b1;
          ram_adr = adr_in;
          adr_d   = adr_in;
          if (wait_cycles != 0) begin
            state_d = WAIT;
            ack_d   = 1'b0;
            cnt_d   = wait_load;
          end
        end else if (ack) begin
          if (bus.wbs_we_i) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end
          if (bus.wbs_cti_i == CTI_INCBURST) begin
            adr_d = nxt;
            // A write beat owns the single port; its next-beat read data is never consumed.
            if (!bus.wbs_we_i) begin
              ram_en  = 1'b1;
              ram_adr = nxt;
            end
          end else begin
            state_d = IDLE;
            ack_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase

    if (!bus.wbs_cyc_i) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      cnt_d   = 4'd0;
      ram_en  = 1'b0;
      ram_we  = 1'b0;
    end
  end

  vl_ram_be #(.adr_width(adr_width)) u_ram (
    .clk  (wbs_clk),
    .rst  (wbs_rst),
    .en   (ram_en),
    .we   (ram_we),
    .sel  (bus.wbs_sel_i),
    .adr  (ram_adr),
    .wdat (bus.wbs_dat_i),
    .rdat (bus.wbs_dat_o)
  );

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// tb/tb_wb_burst_ram_slave.sv - directed self-checking bench for wb_burst_ram_slave
module tb_wb_burst_ram_slave;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, tgt;
  logic [29:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [1:0]  bte;
  logic [2:0]  cti;
  wire         ack;
  wire  [31:0] rdat;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  logic [31:0] got;

  always #5 clk = ~clk;

  wb_burst_ram_slave_if bus0 ();
  wb_burst_ram_slave_if bus1 ();

  // tgt selects which slave sees the cycle: 0 = no wait states, 1 = three wait states.
  assign bus0.wbs_dat_i = dat;
  assign bus0.wbs_adr_i = adr;
  assign bus0.wbs_sel_i = sel;
  assign bus0.wbs_bte_i = bte;
  assign bus0.wbs_cti_i = cti;
  assign bus0.wbs_we_i  = we;
  assign bus0.wbs_cyc_i = cyc & ~tgt;
  assign bus0.wbs_stb_i = stb;
  assign bus1.wbs_dat_i = dat;
  assign bus1.wbs_adr_i = adr;
  assign bus1.wbs_sel_i = sel;
  assign bus1.wbs_bte_i = bte;
  assign bus1.wbs_cti_i = cti;
  assign bus1.wbs_we_i  = we;
  assign bus1.wbs_cyc_i = cyc & tgt;
  assign bus1.wbs_stb_i = stb;
  assign ack  = tgt ? bus1.wbs_ack_o : bus0.wbs_ack_o;
  assign rdat = tgt ? bus1.wbs_dat_o : bus0.wbs_dat_o;

  wb_burst_ram_slave #(.adr_width(10), .wait_cycles(0)) dut0 (
    .wbs_clk (clk), .wbs_rst (rst), .bus (bus0.slave)
  );
  wb_burst_ram_slave #(.adr_width(10), .wait_cycles(3)) dut1 (
    .wbs_clk (clk), .wbs_rst (rst), .bus (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int l);
    l = 0;
    @(negedge clk);
    while (ack !== 1'b1 && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
    int l;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
    cti = CTI_CLASSIC; bte = BTE_LINEAR;
    wait_ack(l);
    check("wr_latency", 32'(l), tgt ? 32'd4 : 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    int l;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    cti = CTI_CLASSIC; bte = BTE_LINEAR;
    wait_ack(l);
    check("rd_latency", 32'(l), tgt ? 32'd4 : 32'd1);
    d = rdat;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  logic [29:0] pl_adr [10] = '{30'h04, 30'h05, 30'h06, 30'h07, 30'h32,
                               30'h33, 30'h52, 30'h40, 30'h41, 30'h80};

  initial begin
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; tgt = 1'b0;
    adr = '0; dat = '0; sel = 4'hF; bte = BTE_LINEAR; cti = CTI_CLASSIC;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack0", 32'(bus0.wbs_ack_o), 32'd0);
    check("reset_dat0", bus0.wbs_dat_o, 32'd0);
    check("reset_ack1", 32'(bus1.wbs_ack_o), 32'd0);
    check("reset_dat1", bus1.wbs_dat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Classic write then read.
    wr(30'h10, 32'hA5A5_1234, 4'hF);
    rd(30'h10, got);
    check("classic_rd", got, 32'hA5A5_1234);

    // Byte-lane write, then an all-lanes-off write that must change nothing.
    wr(30'h10, 32'hFFFF_FFFF, 4'hF);
    wr(30'h10, 32'h1122_3344, 4'b0101);
    rd(30'h10, got);
    check("byte_lane", got, 32'hFF22_FF44);
    wr(30'h10, 32'h0000_0000, 4'b0000);
    rd(30'h10, got);
    check("sel0_nochange", got, 32'hFF22_FF44);

    // Preload known words.
    for (int i = 0; i < 10; i++) wr(pl_adr[i], 32'h5000_0000 | 32'(pl_adr[i]), 4'hF);
    wr(30'h81, 32'h5000_0081, 4'hF);

    // wrap4 read burst starting at 6.
    begin
      logic [29:0] seq [4] = '{30'h6, 30'h7, 30'h4, 30'h5};
      cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = BTE_WRAP4;
      for (int i = 0; i < 4; i++) begin
        adr = seq[i];
        cti = (i == 3) ? CTI_ENDOFBURST : CTI_INCBURST;
        if (i == 0) begin
          wait_ack(lat);
          check("wrap4_lat", 32'(lat), 32'd1);
        end else begin
          @(negedge clk);
          check("wrap4_ack", 32'(ack), 32'd1);
        end
        check("wrap4_dat", rdat, 32'h5000_0000 | 32'(seq[i]));
        @(posedge clk); #1;
      end
      adr = 30'h5; cti = CTI_CLASSIC;
      @(negedge clk);
      check("wrap4_idle_noack", 32'(ack), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("wrap4_new_ack", 32'(ack), 32'd1);
      check("wrap4_new_dat", rdat, 32'h5000_0005);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
    end

    // wrap16 write burst on the three-wait-state slave, master stall at beat 5.
    tgt = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = BTE_WRAP16; sel = 4'hF;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        stb = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("wrap16_stall_noack", 32'(ack), 32'd0);
          @(posedge clk); #1;
        end
        stb = 1'b1;
      end
      adr = 30'h20 | 30'((4'hE + 4'(i)) & 4'hF);
      dat = 32'hC000_0000 | 32'(i);
      cti = (i == 15) ? CTI_ENDOFBURST : CTI_INCBURST;
      if (i == 0) begin
        wait_ack(lat);
        check("wrap16_first_lat", 32'(lat), 32'd4);
      end else begin
        @(negedge clk);
        check("wrap16_ack", 32'(ack), 32'd1);
      end
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd(30'h20 | 30'((4'hE + 4'(i)) & 4'hF), got);
      check("wrap16_mem", got, 32'hC000_0000 | 32'(i));
    end
    tgt = 1'b0;

    // Linear write burst aborted by dropping cyc after two beats.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = BTE_LINEAR; cti = CTI_INCBURST;
    adr = 30'h30; dat = 32'hB000_0030;
    wait_ack(lat);
    check("abort_lat", 32'(lat), 32'd1);
    @(posedge clk); #1;
    adr = 30'h31; dat = 32'hB000_0031;
    @(negedge clk);
    check("abort_beat2_ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; adr = 30'h32; dat = 32'hB000_0032;
    @(negedge clk);
    check("abort_ack0", 32'(ack), 32'd0);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    rd(30'h30, got); check("abort_mem30", got, 32'hB000_0030);
    rd(30'h31, got); check("abort_mem31", got, 32'hB000_0031);
    rd(30'h32, got); check("abort_mem32", got, 32'h5000_0032);
    rd(30'h33, got); check("abort_mem33", got, 32'h5000_0033);

    // Reset asserted in the middle of a linear write burst.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = BTE_LINEAR; cti = CTI_INCBURST;
    adr = 30'h50; dat = 32'hE000_0050;
    wait_ack(lat);
    @(posedge clk); #1;
    adr = 30'h51; dat = 32'hE000_0051;
    @(negedge clk);
    @(posedge clk); #1;
    adr = 30'h52; dat = 32'hE000_0052;
    @(negedge clk);
    check("rst_pre_ack", 32'(ack), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ack", 32'(ack), 32'd0);
    check("rst_async_dat", rdat, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(30'h50, got); check("rst_mem50", got, 32'hE000_0050);
    rd(30'h51, got); check("rst_mem51", got, 32'hE000_0051);
    rd(30'h52, got); check("rst_mem52", got, 32'h5000_0052);

    // Address mismatch inside a linear read burst.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = BTE_LINEAR; cti = CTI_INCBURST;
    adr = 30'h40;
    wait_ack(lat);
    check("mm_first_dat", rdat, 32'h5000_0040);
    @(posedge clk); #1;
    adr = 30'h80;
    @(negedge clk);
    check("mm_noack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mm_reack", 32'(ack), 32'd1);
    check("mm_dat80", rdat, 32'h5000_0080);
    @(posedge clk); #1;
    adr = 30'h81; cti = CTI_ENDOFBURST;
    @(negedge clk);
    check("mm_ack81", 32'(ack), 32'd1);
    check("mm_dat81", rdat, 32'h5000_0081);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
